// File: rtl/jk_ff_pkg.sv
// Shared JK opcode encoding ({j,k}) and the per-bit next-state decode used by
// every jk_bit cell.
package jk_ff_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'b00,
    CLR  = 2'b01,
    SET  = 2'b10,
    TOG  = 2'b11
  } jk_op_e;

  function automatic logic jk_next(input jk_op_e op, input logic cur);
    logic nxt;
    nxt = cur;
    case (op)
      HOLD:    nxt = cur;
      CLR:     nxt = 1'b0;
      SET:     nxt = 1'b1;
      TOG:     nxt = ~cur;
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/jk_bit.sv
// Single JK storage cell: asynchronous active-low clear/preset (clear wins)
// in front of a rising-edge JK next-state decode.
module jk_bit
  import jk_ff_pkg::*;
(
  input  logic j,
  input  logic k,
  input  logic clk,
  input  logic set,
  input  logic reset,
  output logic q
);

  logic   q_q;
  logic   q_d;
  jk_op_e op;

  assign op  = jk_op_e'({j, k});
  assign q_d = jk_next(op, q_q);

  // Releasing either control produces no edge here, so q holds until the next clk.
  always_ff @(posedge clk or negedge reset or negedge set) begin
    if (!reset) begin
      q_q <= 1'b0;
    end else if (!set) begin
      q_q <= 1'b1;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/jk_ff.sv
// WIDTH independent JK flip-flops sharing clock, preset and clear; qb is the
// bitwise complement of q at all times.
module jk_ff #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic             clk,
  input  logic             set,
  input  logic             reset,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jk_bit u_bit (
      .j     (j[i]),
      .k     (k[i]),
      .clk   (clk),
      .set   (set),
      .reset (reset),
      .q     (q[i])
    );
  end

  assign qb = ~q;

endmodule

// File: tb/tb_jk_ff.sv
// Self-checking bench for jk_ff: directed walk through the basic JK and
// async-control cases, then randomized j/k and async pulses against a model.
module tb_jk_ff;

  logic       clk = 1'b1;
  logic       set;
  logic       reset;
  logic       j1, k1;
  logic       q1, qb1;
  logic [3:0] j4, k4;
  logic [3:0] q4, qb4;

  int compareCount  = 0;
  int mismatchCount = 0;

  logic       m1;
  logic [3:0] m4;

  // Rising edges at t = 10, 20, 30, ...
  always #5 clk = ~clk;

  jk_ff #(.WIDTH(1)) dut1 (
    .j     (j1),
    .k     (k1),
    .clk   (clk),
    .set   (set),
    .reset (reset),
    .q     (q1),
    .qb    (qb1)
  );

  jk_ff #(.WIDTH(4)) dut4 (
    .j     (j4),
    .k     (k4),
    .clk   (clk),
    .set   (set),
    .reset (reset),
    .q     (q4),
    .qb    (qb4)
  );

  task automatic checkOutput(input string tag, input logic [3:0] observed,
                             input logic [3:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s at %0t: got %b, expected %b", tag, $time, observed, expected);
    end
  endtask

  task automatic checkBoth(input string tag, input logic e1, input logic [3:0] e4);
    checkOutput({tag, "_q1"},  {3'b000, q1},  {3'b000, e1});
    checkOutput({tag, "_qb1"}, {3'b000, qb1}, {3'b000, ~e1});
    checkOutput({tag, "_q4"},  q4,  e4);
    checkOutput({tag, "_qb4"}, qb4, ~e4);
  endtask

  task automatic applyStimulus(input logic jj, input logic kk);
    j1 = jj;
    k1 = kk;
    j4 = {4{jj}};
    k4 = {4{kk}};
  endtask

  // Characteristic equation Q+ = J&~Q | ~K&Q, applied to whole vectors.
  task automatic modelEdge();
    if (set && reset) begin
      m1 = (j1 & ~m1) | (~k1 & m1);
      m4 = (j4 & ~m4) | (~k4 & m4);
    end
  endtask

  task automatic modelAsync();
    if (!reset) begin
      m1 = 1'b0;
      m4 = 4'h0;
    end else if (!set) begin
      m1 = 1'b1;
      m4 = 4'hF;
    end
  endtask

  initial begin
    set   = 1'b1;
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0);

    @(posedge clk); #1;
    checkBoth("set_e10", 1'b1, 4'hF);
    @(negedge clk); applyStimulus(1'b0, 1'b1);
    @(posedge clk); #1;
    checkBoth("clr_e20", 1'b0, 4'h0);
    @(negedge clk); applyStimulus(1'b0, 1'b0);
    @(posedge clk); #1;
    checkBoth("hold_e30", 1'b0, 4'h0);
    @(negedge clk); applyStimulus(1'b1, 1'b1);
    @(posedge clk); #1;
    checkBoth("tog_e40", 1'b1, 4'hF);
    @(negedge clk); applyStimulus(1'b0, 1'b0);
    @(posedge clk); #1;
    checkBoth("hold_e50", 1'b1, 4'hF);

    @(negedge clk); applyStimulus(1'b1, 1'b1); reset = 1'b0;
    #1;
    checkBoth("rst_async", 1'b0, 4'h0);
    @(posedge clk); #1;
    checkBoth("rst_edge_ign", 1'b0, 4'h0);

    @(negedge clk); reset = 1'b1; set = 1'b0;
    #1;
    checkBoth("set_async", 1'b1, 4'hF);
    @(posedge clk); #1;
    checkBoth("set_edge_ign", 1'b1, 4'hF);

    @(negedge clk); reset = 1'b0;
    #1;
    checkBoth("both_rst_wins", 1'b0, 4'h0);
    @(negedge clk); set = 1'b1;
    #1;
    checkBoth("set_rel_rst_held", 1'b0, 4'h0);
    @(posedge clk); #2; set = 1'b0;
    #1;
    checkBoth("set_again_rst_held", 1'b0, 4'h0);

    @(negedge clk); set = 1'b1; #1; reset = 1'b1;
    #1;
    checkBoth("release_hold", 1'b0, 4'h0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checkBoth($sformatf("tog_seq%0d", i), (i % 2 == 0), {4{(i % 2 == 0)}});
    end

    @(negedge clk);
    j4 = 4'b1010; k4 = 4'b0110;
    j1 = 1'b0;    k1 = 1'b0;
    @(posedge clk); #1;
    checkOutput("vec_mix_q4",  q4,  4'b1010);
    checkOutput("vec_mix_qb4", qb4, 4'b0101);
    checkOutput("vec_mix_q1",  {3'b000, q1}, 4'b0000);

    m1 = 1'b0;
    m4 = 4'b1010;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      j1 = 1'($urandom); k1 = 1'($urandom);
      j4 = 4'($urandom); k4 = 4'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        int kind;
        kind = $urandom_range(0, 2);
        #1;
        if (kind == 0) reset = 1'b0;
        else if (kind == 1) set = 1'b0;
        else begin set = 1'b0; reset = 1'b0; end
        modelAsync();
        #1;
        checkOutput("rnd_async_q1",  {3'b000, q1},  {3'b000, m1});
        checkOutput("rnd_async_qb1", {3'b000, qb1}, {3'b000, ~m1});
        checkOutput("rnd_async_q4",  q4,  m4);
        checkOutput("rnd_async_qb4", qb4, ~m4);
        set = 1'b1;
        #1;
        reset = 1'b1;
      end
      @(posedge clk); #1;
      modelEdge();
      checkOutput("rnd_q1",  {3'b000, q1},  {3'b000, m1});
      checkOutput("rnd_qb1", {3'b000, qb1}, {3'b000, ~m1});
      checkOutput("rnd_q4",  q4,  m4);
      checkOutput("rnd_qb4", qb4, ~m4);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
